// File: rtl/main_fsm.sv
// main_fsm: multicycle RV32I control FSM. Sequences fetch, decode, execute,
// memory and write-back, stalls on mem_ready, and aborts a stalled memory
// access with a one-cycle bus_err pulse after MAX_WAIT stalled cycles.
module main_fsm #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal_op,
  output logic       bus_err
);

  // Counter must hold values up to MAX_WAIT-1; keep at least one bit so a
  // disabled timeout (MAX_WAIT=0) still gives a legal vector.
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = (MAX_WAIT < 1) ? '0 : CW'(MAX_WAIT - 1);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_cnt_next;
  logic            wait_state;
  logic            stall;
  logic            timeout;

  // Stall detection: only the three memory-handshake states look at mem_ready.
  always_comb begin
    wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    stall      = wait_state && !mem_ready;
    timeout    = (MAX_WAIT != 0) && stall && (wait_cnt == LIMIT);
  end

  // State and wait-counter registers; reset lands in FETCH with a clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Immediate format follows the opcode in every state so decode can use it early.
  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Next-state and datapath controls; write enables are masked while in reset.
  always_comb begin
    next_state = state;
    PCUpdate   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    illegal_op = 1'b0;
    bus_err    = 1'b0;

    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_IALU:      next_state = EXECI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_LW)      next_state = MEMREAD;
        else if (opcode == OP_SW) next_state = MEMWRITE;
        else                      next_state = FETCH;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCUpdate   = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase

    // A timed-out access abandons the instruction; FETCH then retries the same PC.
    if (timeout) begin
      bus_err    = 1'b1;
      next_state = FETCH;
    end

    if (!rst_n) begin
      PCUpdate   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      Branch     = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
    end
  end

  // Counter advances only while the state is stalled in place; any exit clears it.
  always_comb begin
    wait_cnt_next = '0;
    if (stall && !timeout && (next_state == state))
      wait_cnt_next = wait_cnt + 1'b1;
  end

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed vectors for main_fsm with MAX_WAIT=4, checking the
// state sequence and every control output each cycle.
module tb_main_fsm;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       illegal_op, bus_err;
  logic [17:0] out_vec;

  int checks = 0;
  int errors = 0;

  main_fsm #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Branch(Branch), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign out_vec = {PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, bus_err};

  // Enables are {PCUpdate,IRWrite,RegWrite,MemWrite,Branch,AdrSrc}; flags are {illegal_op,bus_err}.
  function automatic logic [17:0] mk(input logic [5:0] en, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic [1:0] imm,
                                     input logic [1:0] flags);
    return {en, rs, sa, sb, op, imm, flags};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic ready);
    opcode    = op;
    mem_ready = ready;
  endtask

  // One clock: check state and outputs mid-cycle, then step just past the edge.
  task automatic cycleCheck(input string tag, input logic [3:0] exp_state, input logic [17:0] exp_out);
    @(negedge clk);
    checkOutput({tag, ".state"}, 32'(dut.state), 32'(exp_state));
    checkOutput({tag, ".out"}, 32'(out_vec), 32'(exp_out));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(OP_R, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset.state", 32'(dut.state), 32'd0);
    checkOutput("reset.out", 32'(out_vec), 32'(mk(6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] R-type, zero wait");
    cycleCheck("r.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
    cycleCheck("r.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    cycleCheck("r.execr",  4'd6, mk(6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));
    cycleCheck("r.aluwb",  4'd8, mk(6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    $display("[TB] lw with three stalled MEMREAD cycles");
    applyStimulus(OP_LW, 1'b1);
    cycleCheck("lw.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
    applyStimulus(OP_LW, 1'b0);
    cycleCheck("lw.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    cycleCheck("lw.memadr", 4'd2, mk(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++)
      cycleCheck("lw.memread.stall", 4'd3, mk(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(OP_LW, 1'b1);
    cycleCheck("lw.memread.done", 4'd3, mk(6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    cycleCheck("lw.memwb",  4'd4, mk(6'b001000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    $display("[TB] sw with memory stuck, then FETCH timeout");
    applyStimulus(OP_SW, 1'b1);
    cycleCheck("sw.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00));
    applyStimulus(OP_SW, 1'b0);
    cycleCheck("sw.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00));
    cycleCheck("sw.memadr", 4'd2, mk(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00));
    for (int i = 0; i < 3; i++)
      cycleCheck("sw.memwrite.stall", 4'd5, mk(6'b000101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    cycleCheck("sw.memwrite.timeout", 4'd5, mk(6'b000101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    for (int i = 0; i < 3; i++)
      cycleCheck("refetch.stall", 4'd0, mk(6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00));
    cycleCheck("refetch.timeout", 4'd0, mk(6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01));

    $display("[TB] jal, beq, I-ALU");
    applyStimulus(OP_JAL, 1'b1);
    cycleCheck("jal.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00));
    cycleCheck("jal.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00));
    cycleCheck("jal.jal",    4'd9, mk(6'b100000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00));
    cycleCheck("jal.aluwb",  4'd8, mk(6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00));
    applyStimulus(OP_BEQ, 1'b1);
    cycleCheck("beq.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00));
    cycleCheck("beq.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
    cycleCheck("beq.beq",    4'd10, mk(6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00));
    applyStimulus(OP_IALU, 1'b1);
    cycleCheck("ialu.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
    cycleCheck("ialu.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    cycleCheck("ialu.execi",  4'd7, mk(6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00));
    cycleCheck("ialu.aluwb",  4'd8, mk(6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    $display("[TB] illegal opcode");
    applyStimulus(OP_LUI, 1'b1);
    cycleCheck("ill.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
    cycleCheck("ill.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10));

    $display("[TB] reset during MEMWRITE");
    applyStimulus(OP_SW, 1'b1);
    cycleCheck("rsw.fetch",  4'd0, mk(6'b110000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00));
    applyStimulus(OP_SW, 1'b0);
    cycleCheck("rsw.decode", 4'd1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00));
    cycleCheck("rsw.memadr", 4'd2, mk(6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00));
    @(negedge clk);
    checkOutput("rsw.memwrite.state", 32'(dut.state), 32'd5);
    checkOutput("rsw.memwrite.memwrite", 32'(MemWrite), 32'd1);
    #2;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    checkOutput("rsw.reset.state", 32'(dut.state), 32'd0);
    checkOutput("rsw.reset.memwrite", 32'(MemWrite), 32'd0);
    checkOutput("rsw.reset.out", 32'(out_vec), 32'(mk(6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(OP_SW, 1'b0);
    cycleCheck("rsw.after", 4'd0, mk(6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine that replaces the single-cycle main decoder in the RV32I core. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath mux selects and write enables, and stalls on a memory ready handshake, with a configurable bus timeout. It adds `jal`, illegal-opcode detection and bus-error reporting.

## Interface
- `MAX_WAIT`, default 16: number of consecutive stalled memory cycles before a bus error is raised. A value of 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `PCUpdate`, `IRWrite`, `RegWrite`, `MemWrite`, `Branch`, `AdrSrc` out 1 each: datapath enables and selects.
- `ResultSrc`, `ALUSrcA`, `ALUSrcB`, `ALUOp`, `ImmSrc` out 2 each: datapath selects.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode is seen in DECODE.
- `bus_err` out 1: one-cycle pulse when a memory access times out.

## Operation
- Supported opcodes:
  - lw `0000011`
  - sw `0100011`
  - R-type `0110011`
  - I-ALU `0010011`
  - beq `1100011`
  - jal `1101111`
- State register is 4 bits:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10
  - Codes 11–15 are unreachable and go to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10; `IRWrite`=`PCUpdate`=`mem_ready`.
  - Moves to DECODE when `mem_ready`=1; otherwise holds.
- DECODE:
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00.
  - Next state: lw/sw→MEMADR, R→EXECR, I-ALU→EXECI, jal→JAL, beq→BEQ.
  - Any other opcode: `illegal_op`=1 this cycle, next state FETCH.
- MEMADR:
  - Outputs: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00.
  - Next state: lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: `ResultSrc`=00, `AdrSrc`=1; moves to MEMWB when `mem_ready`=1, otherwise holds.
- MEMWB: `ResultSrc`=01, `RegWrite`=1; next state FETCH.
- MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1 held for the whole stall; moves to FETCH when `mem_ready`=1.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10; next state ALUWB.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10; next state ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1; next state FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCUpdate`=1; next state ALUWB, which writes the link value PC+4.
- BEQ: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `Branch`=1; next state FETCH.
- `ImmSrc` is combinational from `opcode` in every state:
  - lw/I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - other → 00
- Timeout:
  - The wait counter has width `$clog2(MAX_WAIT+1)` (minimum 1).
  - It increments each cycle in FETCH, MEMREAD or MEMWRITE while `mem_ready`=0, and clears on `mem_ready`=1 or on any state change.
  - When the counter equals `MAX_WAIT`-1 and `mem_ready`=0: `bus_err`=1 this cycle, next state FETCH, counter clears.
  - A timed-out FETCH re-fetches the same PC, because `PCUpdate` was never asserted.
  - A timed-out MEMWRITE drops `MemWrite` at the transition.

## Timing
- Reset (`rst_n`=0):
  - State=FETCH and counter=0, asynchronously.
  - While reset is asserted, `PCUpdate`, `IRWrite`, `RegWrite`, `MemWrite`, `Branch`, `illegal_op` and `bus_err` are forced to 0.
  - All selects take their FETCH values: `ALUSrcB`=10, `ResultSrc`=10, all others 00 or 0.
- Reset asserted mid-instruction aborts the instruction; no write enable is issued afterwards.
- Latency with zero-wait memory:
  - R/I-ALU/jal: 4 cycles
  - beq: 3 cycles
  - sw: 4 cycles
  - lw: 5 cycles
- Each stalled cycle adds 1 cycle.
- All transitions occur on the rising edge of `clk`. `illegal_op` and `bus_err` are combinational from state, counter and inputs, and are valid in the same cycle.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored in all other states.

## Test plan
- Reset, then R-type with `mem_ready`=1 held:
  - States go 0→1→6→8→0.
  - `RegWrite`=1 in cycle 4 only.
  - `PCUpdate`=`IRWrite`=1 in cycle 1.
- lw with `mem_ready` low for 3 cycles in MEMREAD:
  - States go 0,1,2,3,3,3,3,4,0.
  - `AdrSrc`=1 throughout MEMREAD.
  - `ResultSrc`=01 and `RegWrite`=1 in MEMWB.
- sw with `MAX_WAIT`=4 and `mem_ready` stuck at 0:
  - `MemWrite`=1 for 4 cycles.
  - `bus_err` pulses on the 4th cycle, then state returns to FETCH with `PCUpdate`=0.
- jal then beq:
  - jal: `ImmSrc`=11, JAL state asserts `PCUpdate`, ALUWB asserts `RegWrite`.
  - beq: `ImmSrc`=10, `Branch`=1 in BEQ, `ALUOp`=01.
- opcode `0110111` in DECODE: `illegal_op`=1 for one cycle, next state FETCH, no write enables asserted.
- `rst_n` pulled low in MEMWRITE with `MemWrite`=1: `MemWrite` drops to 0 in the same cycle (asynchronously); after release, state is FETCH.
